frac_iter_engine: RTL and testbench
===================================

Name: frac_iter_engine

Overview:
- Single-point Mandelbrot escape-time engine; instantiated as `frac_unit_core` inside the fractal renderer.
- Takes a complex constant c = (cx, cy) in signed fixed point and iterates z <- z^2 + c from z = 0.
- Pulses done when |z|^2 > 4 (escape) or when max_iter iterations complete; reports membership on frac_found.
- A host sequencer drives one point at a time via a go/done handshake.

Parameters:
- N, 32, data width of cx/cy and of the z registers (signed two's complement).
- FRAC, 28, fractional bits; 1.0 = 2^FRAC, so 0x1000_0000 = 1.0 and 0x0800_0000 = 0.5 (Q4.28).

Ports:
- frac_clk  in  1  sole clock; all state updates on its rising edge.
- frac_rst  in  1  reset; asynchronous, active-high.
- frac_cx  in  N  signed real part of c, QN-FRAC.FRAC.
- frac_cy  in  N  signed imaginary part of c.
- frac_go  in  1  start request; sampled only in IDLE.
- frac_max_iter  in  16  unsigned iteration limit.
- frac_busy  out  1  high while iterating.
- frac_done_tick  out  1  one-cycle completion pulse.
- frac_found  out  1  1 = no escape within limit (point in set); 0 = escaped.

Behaviour:
- Reset (asynchronous): state IDLE; x, y, iteration count k cleared; frac_busy=0, frac_done_tick=0, frac_found=0.
- IDLE:
  - On frac_go=1, latch cx, cy and max_iter; clear x=y=0 and k=0; go to SQR.
  - frac_busy rises the next cycle.
- SQR (1 cycle): register x*x, y*y and x*y as full 2N-bit signed products.
- EVAL (1 cycle): compute mag = x*x + y*y in 2N+1 bits and compare against 4.0, i.e. 4 << 2*FRAC.
  - If mag > 4.0: escape; found=0; go to DONE.
  - Else if k == max_iter: found=1; go to DONE.
  - Else:
    - x' = (x*x - y*y) >> FRAC + cx.
    - y' = (2*x*y) >> FRAC + cy.
    - Shifts are arithmetic and truncating; compute at N+3 bits.
    - If x' or y' does not fit in N signed bits, treat as escape: found=0, go to DONE.
    - Otherwise store x', y'; k++; go to SQR.
- DONE (1 cycle): frac_done_tick=1, frac_busy=0; return to IDLE.
- frac_busy=1 exactly in SQR and EVAL.
- Latency: the check of z_k occurs in the EVAL at iteration k (k=0 checks z0=0). Done pulses 2*(k_end+1)+1 cycles after the go-sampling edge, where k_end is the index at termination.
- max_iter=0: EVAL at k=0 sees |0|^2 <= 4 and k==max_iter, so found=1 and done pulses after 3 cycles.
- frac_found is registered, updated only on entry to DONE, and held until the next result.
- frac_go while not IDLE is ignored. Input changes after go are ignored because they are latched.
- Reset mid-operation aborts immediately to IDLE; no done pulse.

Optional Feature:
- Macro FRAC_ITER_COUNT_EN.
- When defined: adds output frac_iter_cnt [15:0], which holds the final k (escape index, or max_iter if found), updates together with frac_found, and resets to 0.
- When undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package frac_pkg holds:
  - Constants N and FRAC.
  - ESC_LIMIT = 4 << 2*FRAC.
  - typedef fx_t = logic signed [N-1:0].
  - State enum {IDLE, SQR, EVAL, DONE}.
- One natural sub-module, frac_cplx_sqr: registered x*x, y*y, x*y products (the SQR stage).
- The FSM, escape compare and update stay in the core.

Test Plan:
- cx=0x0800_0000 (0.5), cy=0xF800_0000 (-0.5), max_iter=30 -> escapes at k=5, found=0, busy low after done, single done pulse.
- cx=0x1800_0000 (1.5), cy=0xE800_0000 (-1.5), max_iter=30 -> |z1|^2=4.5, escapes at k=1, found=0.
- cx=0x0300_0000 (0.1875), cy=0xE800_0000 (-1.5), max_iter=30 -> escapes at k=2, found=0.
- cx=0, cy=0, max_iter=30 -> found=1, k=30, done 63 cycles after go edge.
- cx=0xF000_0000 (-1), cy=0, max_iter=0x20 -> period-2 orbit, found=1; then max_iter=0 -> found=1 after 3 cycles.
- Assert frac_go during busy, then assert frac_rst mid-run -> second go ignored; reset returns busy=0, found=0, no done pulse; next go works normally.

Source files
------------

// File: rtl/frac_pkg.sv
// Shared types and constants for the Mandelbrot escape-time engine (Q4.28 fixed point).
// No timing or flow-control content; pure declarations.
package frac_pkg;
    localparam int N    = 32;
    localparam int FRAC = 28;
    localparam int XW   = N + 3;

    typedef logic signed [N-1:0]   fx_t;
    typedef logic signed [2*N-1:0] prod_t;
    typedef logic signed [2*N:0]   mag_t;
    typedef logic signed [XW-1:0]  xw_t;

    // |z|^2 escape threshold: 4.0 scaled by the product's 2*FRAC fraction bits
    localparam mag_t ESC_LIMIT = mag_t'(4) <<< (2 * FRAC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic fits_n(input xw_t v);
        return (v[XW-1:N-1] == '0) || (v[XW-1:N-1] == '1);
    endfunction
endpackage

// File: rtl/frac_cplx_sqr.sv
// Registered x*x, y*y, x*y full-width signed products; one-cycle latency when en is high.
// No backpressure: products hold their value while en is low.
module frac_cplx_sqr
    import frac_pkg::*;
(
    input  logic  frac_clk,
    input  logic  frac_rst,
    input  logic  en,
    input  fx_t   x,
    input  fx_t   y,
    output prod_t xx,
    output prod_t yy,
    output prod_t xy
);
    prod_t xx_q, xx_d;
    prod_t yy_q, yy_d;
    prod_t xy_q, xy_d;

    always_comb begin
        xx_d = xx_q;
        yy_d = yy_q;
        xy_d = xy_q;
        if (en) begin
            xx_d = prod_t'(x) * prod_t'(x);
            yy_d = prod_t'(y) * prod_t'(y);
            xy_d = prod_t'(x) * prod_t'(y);
        end
    end

    always_ff @(posedge frac_clk or posedge frac_rst) begin
        if (frac_rst) begin
            xx_q <= '0;
            yy_q <= '0;
            xy_q <= '0;
        end else begin
            xx_q <= xx_d;
            yy_q <= yy_d;
            xy_q <= xy_d;
        end
    end

    assign xx = xx_q;
    assign yy = yy_q;
    assign xy = xy_q;
endmodule

// File: rtl/frac_iter_engine.sv
// Mandelbrot escape-time core: SQR/EVAL per iteration, done 2*(k_end+1)+1 cycles after go; go ignored unless idle.
// FRAC_ITER_COUNT_EN adds frac_iter_cnt, the final iteration index, updated with frac_found.
module frac_iter_engine
    import frac_pkg::*;
(
    input  logic        frac_clk,
    input  logic        frac_rst,
    input  logic [N-1:0] frac_cx,
    input  logic [N-1:0] frac_cy,
    input  logic        frac_go,
    input  logic [15:0] frac_max_iter,
    output logic        frac_busy,
    output logic        frac_done_tick,
    output logic        frac_found
`ifdef FRAC_ITER_COUNT_EN
    ,
    output logic [15:0] frac_iter_cnt
`endif
);
    state_t      state_q, state_d;
    fx_t         x_q, x_d;
    fx_t         y_q, y_d;
    fx_t         cx_q, cx_d;
    fx_t         cy_q, cy_d;
    logic [15:0] k_q, k_d;
    logic [15:0] max_q, max_d;
    logic        found_q, found_d;
`ifdef FRAC_ITER_COUNT_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    logic  sqr_en;
    prod_t xx, yy, xy;
    mag_t  mag, diff, xy2;
    xw_t   x_new, y_new;

    frac_cplx_sqr u_sqr (
        .frac_clk (frac_clk),
        .frac_rst (frac_rst),
        .en       (sqr_en),
        .x        (x_q),
        .y        (y_q),
        .xx       (xx),
        .yy       (yy),
        .xy       (xy)
    );

    // Next z is formed in N+3 bits; any value that reaches here has |z|<=2, so this never wraps
    always_comb begin
        mag   = mag_t'(xx) + mag_t'(yy);
        diff  = mag_t'(xx) - mag_t'(yy);
        xy2   = mag_t'(xy) <<< 1;
        x_new = xw_t'(diff >>> FRAC) + xw_t'(cx_q);
        y_new = xw_t'(xy2 >>> FRAC) + xw_t'(cy_q);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        k_d     = k_q;
        max_d   = max_q;
        found_d = found_q;
`ifdef FRAC_ITER_COUNT_EN
        cnt_d   = cnt_q;
`endif
        sqr_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (frac_go) begin
                    cx_d    = fx_t'(frac_cx);
                    cy_d    = fx_t'(frac_cy);
                    max_d   = frac_max_iter;
                    x_d     = '0;
                    y_d     = '0;
                    k_d     = '0;
                    state_d = SQR;
                end
            end
            SQR: begin
                sqr_en  = 1'b1;
                state_d = EVAL;
            end
            EVAL: begin
                if (mag > ESC_LIMIT) begin
                    found_d = 1'b0;
                    state_d = DONE;
                end else if (k_q == max_q) begin
                    found_d = 1'b1;
                    state_d = DONE;
                end else if (!fits_n(x_new) || !fits_n(y_new)) begin
                    found_d = 1'b0;
                    state_d = DONE;
                end else begin
                    x_d     = fx_t'(x_new);
                    y_d     = fx_t'(y_new);
                    k_d     = k_q + 16'd1;
                    state_d = SQR;
                end
`ifdef FRAC_ITER_COUNT_EN
                if (state_d == DONE) begin
                    cnt_d = k_q;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge frac_clk or posedge frac_rst) begin
        if (frac_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            k_q     <= '0;
            max_q   <= '0;
            found_q <= 1'b0;
`ifdef FRAC_ITER_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            k_q     <= k_d;
            max_q   <= max_d;
            found_q <= found_d;
`ifdef FRAC_ITER_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign frac_busy      = (state_q == SQR) || (state_q == EVAL);
    assign frac_done_tick = (state_q == DONE);
    assign frac_found     = found_q;
`ifdef FRAC_ITER_COUNT_EN
    assign frac_iter_cnt  = cnt_q;
`endif
endmodule

// File: tb/tb_frac_iter_engine.sv
// Directed + random bench for frac_iter_engine with a queue scoreboard of expected found/latency.
// A wide-integer reference model supplies expectations for the random points.
module tb_frac_iter_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cx = '0;
    logic [31:0] cy = '0;
    logic        go = 1'b0;
    logic [15:0] mi = '0;
    logic        busy;
    logic        done;
    logic        found;
`ifdef FRAC_ITER_COUNT_EN
    logic [15:0] iter_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic found;
        int   k;
        int   cycles;
    } exp_t;
    exp_t sb[$];

    frac_iter_engine dut (
        .frac_clk       (clk),
        .frac_rst       (rst),
        .frac_cx        (cx),
        .frac_cy        (cy),
        .frac_go        (go),
        .frac_max_iter  (mi),
        .frac_busy      (busy),
        .frac_done_tick (done),
        .frac_found     (found)
`ifdef FRAC_ITER_COUNT_EN
        ,
        .frac_iter_cnt  (iter_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    localparam logic signed [127:0] HI  = (128'sd1 <<< 31) - 128'sd1;
    localparam logic signed [127:0] LO  = -(128'sd1 <<< 31);
    localparam logic signed [127:0] LIM = 128'sd4 <<< 56;

    function automatic void model(input logic signed [31:0] mcx, input logic signed [31:0] mcy,
                                  input int mmi, output logic f, output int k);
        logic signed [127:0] x, y, xx, yy, xn, yn, c_r, c_i;
        x = 0;
        y = 0;
        c_r = mcx;
        c_i = mcy;
        f = 1'b1;
        k = mmi;
        for (int i = 0; i <= mmi; i++) begin
            xx = x * x;
            yy = y * y;
            if (xx + yy > LIM) begin
                f = 1'b0; k = i; return;
            end
            if (i == mmi) begin
                f = 1'b1; k = i; return;
            end
            xn = ((xx - yy) >>> 28) + c_r;
            yn = ((128'sd2 * x * y) >>> 28) + c_i;
            if (xn > HI || xn < LO || yn > HI || yn < LO) begin
                f = 1'b0; k = i; return;
            end
            x = xn;
            y = yn;
        end
    endfunction

    // Drives one point, optionally pokes go mid-run with other operands, and scores the result.
    task automatic run_point(input logic [31:0] pcx, input logic [31:0] pcy, input logic [15:0] pmi,
                             input logic ef, input int ek, input bit inject);
        exp_t e;
        int   cyc;
        bit   seen;
        sb.push_back('{found: ef, k: ek, cycles: 2 * (ek + 1) + 1});
        @(negedge clk);
        cx = pcx; cy = pcy; mi = pmi; go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        cx = $urandom; cy = $urandom; mi = 16'($urandom);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy_rise", {31'b0, busy}, 32'd1);
            if (inject && cyc == 4) begin
                cx = '0; cy = '0; mi = '0; go = 1'b1;
            end
            if (inject && cyc == 6) go = 1'b0;
            if (done) seen = 1'b1;
        end
        go = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_latency", cyc, e.cycles);
            check("found", {31'b0, found}, {31'b0, e.found});
            check("busy_in_done", {31'b0, busy}, 32'd0);
`ifdef FRAC_ITER_COUNT_EN
            check("iter_cnt", {16'b0, iter_cnt}, e.k);
`endif
            @(negedge clk);
            check("done_single", {31'b0, done}, 32'd0);
            check("busy_after", {31'b0, busy}, 32'd0);
            check("found_held", {31'b0, found}, {31'b0, e.found});
        end
    endtask

    initial begin
        logic        mf;
        int          mk;
        logic [31:0] rcx, rcy;
        logic [15:0] rmi;
        bit          saw;

        rst = 1'b1;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_found", {31'b0, found}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // escape at k=5, with an ignored go pulse mid-run
        run_point(32'h0800_0000, 32'hF800_0000, 16'd30, 1'b0, 5, 1'b1);
        run_point(32'h1800_0000, 32'hE800_0000, 16'd30, 1'b0, 1, 1'b0);
        run_point(32'h0300_0000, 32'hE800_0000, 16'd30, 1'b0, 2, 1'b0);
        run_point(32'h0000_0000, 32'h0000_0000, 16'd30, 1'b1, 30, 1'b0);
        run_point(32'hF000_0000, 32'h0000_0000, 16'h20, 1'b1, 32, 1'b0);
        run_point(32'hF000_0000, 32'h0000_0000, 16'd0, 1'b1, 0, 1'b0);

        // abort mid-run: found was 1, reset must clear it with no done pulse
        @(negedge clk);
        cx = '0; cy = '0; mi = 16'd30; go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_found", {31'b0, found}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (done || busy) saw = 1'b1;
        end
        check("no_activity_after_abort", {31'b0, saw}, 32'd0);

        run_point(32'h1800_0000, 32'hE800_0000, 16'd30, 1'b0, 1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rcx = $urandom_range(32'h4000_0000, 0) - 32'h2000_0000;
            rcy = $urandom_range(32'h4000_0000, 0) - 32'h2000_0000;
            rmi = 16'($urandom_range(40, 0));
            model(rcx, rcy, int'(rmi), mf, mk);
            run_point(rcx, rcy, rmi, mf, mk, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
